// File: rtl/multicycle_control_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit_if
// Brief    : IR-field inputs and datapath control outputs of the multi-cycle
//            control unit, grouped with controller/datapath modports.
// Revision : 1.0 - initial release
// ============================================================================
interface multicycle_control_unit_if #(
    parameter int ALU_OP_W = 3,
    parameter int CNT_W    = 32
);
    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic                funct7_5;
    logic                zero;
    logic                mem_ready;
    logic                pc_write;
    logic                pc_src;
    logic                ir_write;
    logic                iord;
    logic                reg_write;
    logic                alu_src;
    logic                mem_read;
    logic                mem_write;
    logic                mem_to_reg;
    logic [ALU_OP_W-1:0] alu_op;
    logic                retire;
    logic [CNT_W-1:0]    instret;
    logic                fault;
    logic [2:0]          state;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, pc_src, ir_write, iord, reg_write, alu_src,
               mem_read, mem_write, mem_to_reg, alu_op, retire, instret,
               fault, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, pc_src, ir_write, iord, reg_write, alu_src,
               mem_read, mem_write, mem_to_reg, alu_op, retire, instret,
               fault, state
    );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : FETCH/DECODE/EXEC/MEM/WB sequencer for a shared-memory RV32
//            subset with memory timeout, sticky fault and retire counter.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int ALU_OP_W    = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    multicycle_control_unit_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam logic [6:0] c_OP_R  = 7'b0110011;
    localparam logic [6:0] c_OP_I  = 7'b0010011;
    localparam logic [6:0] c_OP_LW = 7'b0000011;
    localparam logic [6:0] c_OP_SW = 7'b0100011;
    localparam logic [6:0] c_OP_BR = 7'b1100011;

    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b100;

    // Counter holds at most MEM_TIMEOUT-1 before the fault transition fires.
    localparam int c_WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LIMIT =
        c_WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]    r_instret;

    logic       w_fn_ok, w_is_r, w_is_i, w_is_lw, w_is_sw, w_is_br;
    logic       w_legal, w_taken, w_timeout;
    logic [2:0] w_fn_op, w_ex_op;

    always_comb begin
        w_fn_ok = 1'b1;
        w_fn_op = c_ALU_ADD;
        case (bus.funct3)
            3'b000:  w_fn_op = c_ALU_ADD;
            3'b111:  w_fn_op = c_ALU_AND;
            3'b110:  w_fn_op = c_ALU_OR;
            3'b010:  w_fn_op = c_ALU_SLT;
            default: w_fn_ok = 1'b0;
        endcase
        w_is_r  = (bus.opcode == c_OP_R) && w_fn_ok;
        w_is_i  = (bus.opcode == c_OP_I) && w_fn_ok;
        w_is_lw = (bus.opcode == c_OP_LW) && (bus.funct3 == 3'b010);
        w_is_sw = (bus.opcode == c_OP_SW) && (bus.funct3 == 3'b010);
        w_is_br = (bus.opcode == c_OP_BR) && (bus.funct3[2:1] == 2'b00);
        w_legal = w_is_r | w_is_i | w_is_lw | w_is_sw | w_is_br;
        // funct7_5 only selects SUB for R-type funct3=000.
        w_ex_op = (w_is_r && bus.funct3 == 3'b000 && bus.funct7_5) ? c_ALU_SUB : w_fn_op;
        w_taken = bus.funct3[0] ? ~bus.zero : bus.zero;
    end

    assign w_timeout = (MEM_TIMEOUT != 0) && (r_wait == c_WAIT_LIMIT);

    state_t     w_next;
    logic       w_pc_write, w_pc_src, w_ir_write, w_iord, w_reg_write, w_alu_src;
    logic       w_mem_read, w_mem_write, w_mem_to_reg, w_retire, w_fault;
    logic [2:0] w_alu_op;

    always_comb begin
        w_next       = r_state;
        w_pc_write   = 1'b0;
        w_pc_src     = 1'b0;
        w_ir_write   = 1'b0;
        w_iord       = 1'b0;
        w_reg_write  = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_mem_to_reg = 1'b0;
        w_retire     = 1'b0;
        w_fault      = 1'b0;
        w_alu_op     = c_ALU_ADD;
        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (bus.mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: w_next = w_legal ? S_EXEC : S_FAULT;
            S_EXEC: begin
                if (w_is_r || w_is_i) begin
                    w_alu_src = w_is_i;
                    w_alu_op  = w_ex_op;
                    w_next    = S_WB;
                end else if (w_is_lw || w_is_sw) begin
                    w_alu_src = 1'b1;
                    w_next    = S_MEM;
                end else if (w_is_br) begin
                    w_alu_op   = c_ALU_SUB;
                    w_retire   = 1'b1;
                    w_pc_write = w_taken;
                    w_pc_src   = w_taken;
                    w_next     = S_FETCH;
                end else begin
                    w_next = S_FAULT;
                end
            end
            S_MEM: begin
                w_iord      = 1'b1;
                w_alu_src   = 1'b1;
                w_mem_read  = w_is_lw;
                w_mem_write = w_is_sw;
                if (bus.mem_ready) begin
                    w_retire = w_is_sw;
                    w_next   = w_is_lw ? S_WB : (w_is_sw ? S_FETCH : S_FAULT);
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = w_is_lw;
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_FAULT: w_fault = 1'b1;
            default: w_next  = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            // Any state change clears the wait counter, so it restarts on entry.
            if ((r_state == S_FETCH || r_state == S_MEM) && w_next == r_state)
                r_wait <= r_wait + 1'b1;
            else
                r_wait <= '0;
            if (w_retire)
                r_instret <= r_instret + 1'b1;
        end
    end

    assign bus.pc_write   = w_pc_write   & ~rst;
    assign bus.pc_src     = w_pc_src     & ~rst;
    assign bus.ir_write   = w_ir_write   & ~rst;
    assign bus.iord       = w_iord       & ~rst;
    assign bus.reg_write  = w_reg_write  & ~rst;
    assign bus.alu_src    = w_alu_src    & ~rst;
    assign bus.mem_read   = w_mem_read   & ~rst;
    assign bus.mem_write  = w_mem_write  & ~rst;
    assign bus.mem_to_reg = w_mem_to_reg & ~rst;
    assign bus.retire     = w_retire     & ~rst;
    assign bus.fault      = w_fault      & ~rst;
    assign bus.alu_op     = rst ? '0 : ALU_OP_W'(w_alu_op);
    assign bus.instret    = r_instret;
    assign bus.state      = r_state;
endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Randomized bench comparing the control unit against a cycle trace
//            built from the instruction table and timeout rule.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;
    localparam int c_T = 15;

    localparam logic [10:0] K_PCW  = 11'h400, K_PCS  = 11'h200, K_IRW = 11'h100;
    localparam logic [10:0] K_IORD = 11'h080, K_REGW = 11'h040, K_ASRC = 11'h020;
    localparam logic [10:0] K_MRD  = 11'h010, K_MWR  = 11'h008, K_M2R = 11'h004;
    localparam logic [10:0] K_RET  = 11'h002, K_FLT  = 11'h001;

    localparam logic [2:0] CL_R = 3'd0, CL_I = 3'd1, CL_LW = 3'd2, CL_SW = 3'd3;
    localparam logic [2:0] CL_BEQ = 3'd4, CL_BNE = 3'd5, CL_ILL = 3'd7;

    typedef struct packed {
        logic [6:0] op; logic [2:0] f3; logic f7; logic f7_care;
        logic [2:0] cls; logic [2:0] alu;
    } enc_t;

    typedef struct packed {
        logic [2:0] st; logic rdy; logic [10:0] ctl; logic [2:0] op;
    } step_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [6:0] opcode = 7'b0110011;
    logic [2:0] funct3 = 3'b000;
    logic funct7_5 = 1'b0, zero = 1'b0, mem_ready = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALU_OP_W(3), .CNT_W(32)) bus ();
    multicycle_control_unit_if #(.ALU_OP_W(3), .CNT_W(4))  bus4 ();

    assign bus.opcode   = opcode;   assign bus4.opcode   = opcode;
    assign bus.funct3   = funct3;   assign bus4.funct3   = funct3;
    assign bus.funct7_5 = funct7_5; assign bus4.funct7_5 = funct7_5;
    assign bus.zero     = zero;     assign bus4.zero     = zero;
    assign bus.mem_ready = mem_ready; assign bus4.mem_ready = mem_ready;

    multicycle_control_unit #(.ALU_OP_W(3), .MEM_TIMEOUT(c_T), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus));
    multicycle_control_unit #(.ALU_OP_W(3), .MEM_TIMEOUT(c_T), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4));

    int n_checks = 0;
    int n_fail   = 0;
    int unsigned retired = 0;
    enc_t isa [0:13];

    function automatic logic [10:0] actual_ctl();
        return {bus.pc_write, bus.pc_src, bus.ir_write, bus.iord, bus.reg_write,
                bus.alu_src, bus.mem_read, bus.mem_write, bus.mem_to_reg,
                bus.retire, bus.fault};
    endfunction

    function automatic step_t mk(input logic [2:0] st, input logic rdy,
                                 input logic [10:0] ctl, input logic [2:0] op);
        step_t s;
        s.st = st; s.rdy = rdy; s.ctl = ctl; s.op = op;
        return s;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic init_isa();
        isa[0]  = '{7'b0110011, 3'b000, 1'b0, 1'b1, CL_R, 3'b000};
        isa[1]  = '{7'b0110011, 3'b000, 1'b1, 1'b1, CL_R, 3'b001};
        isa[2]  = '{7'b0110011, 3'b111, 1'b0, 1'b0, CL_R, 3'b010};
        isa[3]  = '{7'b0110011, 3'b110, 1'b0, 1'b0, CL_R, 3'b011};
        isa[4]  = '{7'b0110011, 3'b010, 1'b0, 1'b0, CL_R, 3'b100};
        isa[5]  = '{7'b0010011, 3'b000, 1'b0, 1'b0, CL_I, 3'b000};
        isa[6]  = '{7'b0010011, 3'b111, 1'b0, 1'b0, CL_I, 3'b010};
        isa[7]  = '{7'b0010011, 3'b110, 1'b0, 1'b0, CL_I, 3'b011};
        isa[8]  = '{7'b0010011, 3'b010, 1'b0, 1'b0, CL_I, 3'b100};
        isa[9]  = '{7'b0000011, 3'b010, 1'b0, 1'b0, CL_LW, 3'b000};
        isa[10] = '{7'b0100011, 3'b010, 1'b0, 1'b0, CL_SW, 3'b000};
        isa[11] = '{7'b1100011, 3'b000, 1'b0, 1'b0, CL_BEQ, 3'b001};
        isa[12] = '{7'b1100011, 3'b001, 1'b0, 1'b0, CL_BNE, 3'b001};
        isa[13] = '{7'b1100011, 3'b001, 1'b0, 1'b0, CL_BNE, 3'b001};
    endtask

    task automatic classify(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            output logic [2:0] cls, output logic [2:0] alu);
        cls = CL_ILL;
        alu = 3'b000;
        foreach (isa[k])
            if (isa[k].op == op && isa[k].f3 == f3 && (!isa[k].f7_care || isa[k].f7 == f7)) begin
                cls = isa[k].cls;
                alu = isa[k].alu;
            end
    endtask

    // Expected trace: fw/mw are not-ready cycles in FETCH/MEM; stop_after<0 runs to the end.
    task automatic run_instr(input string name, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic z, input int fw, input int mw,
                             input int stop_after);
        step_t tr[$];
        logic [2:0] cls, alu;
        logic [10:0] mc;
        bit faulted = 0;
        classify(op, f3, f7, cls, alu);
        for (int k = 0; k < fw && k < c_T; k++) tr.push_back(mk(3'd0, 1'b0, K_MRD, 3'd0));
        if (fw >= c_T) faulted = 1;
        else begin
            tr.push_back(mk(3'd0, 1'b1, K_MRD | K_IRW | K_PCW, 3'd0));
            tr.push_back(mk(3'd1, rb(), 11'd0, 3'd0));
            case (cls)
                CL_R, CL_I: begin
                    tr.push_back(mk(3'd2, rb(), (cls == CL_I) ? K_ASRC : 11'd0, alu));
                    tr.push_back(mk(3'd4, rb(), K_REGW | K_RET, 3'd0));
                end
                CL_LW, CL_SW: begin
                    mc = K_IORD | K_ASRC | ((cls == CL_LW) ? K_MRD : K_MWR);
                    tr.push_back(mk(3'd2, rb(), K_ASRC, alu));
                    for (int k = 0; k < mw && k < c_T; k++) tr.push_back(mk(3'd3, 1'b0, mc, 3'd0));
                    if (mw >= c_T) faulted = 1;
                    else begin
                        tr.push_back(mk(3'd3, 1'b1, mc | ((cls == CL_SW) ? K_RET : 11'd0), 3'd0));
                        if (cls == CL_LW) tr.push_back(mk(3'd4, rb(), K_REGW | K_M2R | K_RET, 3'd0));
                    end
                end
                CL_BEQ, CL_BNE: begin
                    mc = ((cls == CL_BEQ) ? z : !z) ? (K_PCW | K_PCS) : 11'd0;
                    tr.push_back(mk(3'd2, rb(), K_RET | mc, alu));
                end
                default: faulted = 1;
            endcase
        end
        if (faulted) repeat (3) tr.push_back(mk(3'd5, rb(), K_FLT, 3'd0));

        foreach (tr[i]) begin
            if (stop_after >= 0 && i >= stop_after) break;
            @(negedge clk);
            rst = 1'b0; opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
            mem_ready = tr[i].rdy;
            #1;
            n_checks++;
            if (bus.state !== tr[i].st) begin
                n_fail++;
                $display("FAIL %s state step %0d: got %0d want %0d", name, i, bus.state, tr[i].st);
            end
            n_checks++;
            if (actual_ctl() !== tr[i].ctl) begin
                n_fail++;
                $display("FAIL %s ctl step %0d: got %b want %b", name, i, actual_ctl(), tr[i].ctl);
            end
            n_checks++;
            if (bus.alu_op !== tr[i].op) begin
                n_fail++;
                $display("FAIL %s alu_op step %0d: got %b want %b", name, i, bus.alu_op, tr[i].op);
            end
            n_checks++;
            if (bus.instret !== retired) begin
                n_fail++;
                $display("FAIL %s instret step %0d: got %0d want %0d", name, i, bus.instret, retired);
            end
            n_checks++;
            if (bus4.instret !== 4'(retired % 16)) begin
                n_fail++;
                $display("FAIL %s instret4 step %0d: got %0d want %0d", name, i, bus4.instret, retired % 16);
            end
            if ((tr[i].ctl & K_RET) != 0) retired++;
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b1; zero = rb();
        #1;
        n_checks++;
        if (actual_ctl() !== 11'd0 || bus.alu_op !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_ctl: got %b/%b want 0", actual_ctl(), bus.alu_op);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (bus.state !== 3'd0 || bus.instret !== 32'd0 || bus4.instret !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: state=%0d instret=%0d/%0d want 0", bus.state, bus.instret, bus4.instret);
        end
        retired = 0;
    endtask

    task automatic test_add_and_abort();
        test_reset();
        run_instr("add", 7'b0110011, 3'b000, 1'b0, rb(), 0, 0, -1);
        run_instr("lw_abort", 7'b0000011, 3'b010, 1'b0, rb(), 0, 5, 5);
        test_reset();
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait", 7'b0000011, 3'b010, 1'b0, rb(), 0, 3, -1);
        run_instr("sw_wait", 7'b0100011, 3'b010, 1'b1, rb(), 2, 2, -1);
    endtask

    task automatic test_branch();
        run_instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, -1);
        run_instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, -1);
        run_instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 1'b0, 1, 0, -1);
        run_instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0, -1);
    endtask

    task automatic test_timeout();
        run_instr("fetch_timeout", 7'b0110011, 3'b000, 1'b0, 1'b0, c_T, 0, -1);
        test_reset();
        run_instr("ready_wins", 7'b0110011, 3'b000, 1'b0, 1'b0, c_T - 1, 0, -1);
        run_instr("mem_timeout", 7'b0000011, 3'b010, 1'b0, 1'b0, 0, c_T, -1);
        test_reset();
    endtask

    task automatic test_illegal();
        logic [6:0] op;
        logic [2:0] f3, cls, alu;
        run_instr("ill_r001", 7'b0110011, 3'b001, 1'b0, 1'b0, 0, 0, -1);
        test_reset();
        run_instr("ill_op7f", 7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, -1);
        test_reset();
        for (int n = 0; n < 4; n++) begin
            op = 7'($urandom); f3 = 3'($urandom);
            classify(op, f3, 1'b0, cls, alu);
            if (cls == CL_ILL) begin
                run_instr("ill_rand", op, f3, 1'b0, rb(), 0, 0, -1);
                test_reset();
            end
        end
    endtask

    task automatic test_wrap_sub_slti();
        test_reset();
        repeat (16) run_instr("wrap_add", 7'b0110011, 3'b000, 1'b0, rb(), 0, 0, -1);
        run_instr("sub", 7'b0110011, 3'b000, 1'b1, rb(), 0, 0, -1);
        run_instr("slti", 7'b0010011, 3'b010, 1'b1, rb(), 0, 0, -1);
    endtask

    task automatic test_back_to_back();
        int idx;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 13);
            run_instr("rand", isa[idx].op, isa[idx].f3,
                      isa[idx].f7_care ? isa[idx].f7 : rb(), rb(),
                      ($urandom_range(0, 7) == 0) ? 14 : $urandom_range(0, 3),
                      $urandom_range(0, 3), -1);
        end
    endtask

    initial begin
        init_isa();
        test_reset();
        test_add_and_abort();
        test_lw_wait();
        test_branch();
        test_timeout();
        test_illegal();
        test_wrap_sub_slti();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Multi-cycle successor to the single-cycle control unit: an FSM that sequences each instruction through fetch, decode, execute, memory and writeback, and drives the datapath enables for a shared-memory 32-bit RISC-V-subset CPU. It adds a memory ready handshake with timeout, I-type ALU ops, BNE, illegal-instruction detection, a sticky fault state and a retired-instruction counter. It sits between the instruction register (IR) / ALU zero flag and the datapath muxes and enables.

## Interface
- ALU_OP_W, 3, width of alu_op; must be ≥3; bits above [2:0] are always 0
- MEM_TIMEOUT, 15, consecutive not-ready wait cycles before fault; 0 disables the timeout
- CNT_W, 32, width of instret

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  7  IR[6:0]; stable from DECODE until the instruction ends
- funct3  in  3  IR[14:12]
- funct7_5  in  1  IR[30]
- zero  in  1  ALU zero flag, valid in EXEC
- mem_ready  in  1  memory completes the access this cycle
- pc_write  out  1  PC load enable
- pc_src  out  1  0 = PC+4, 1 = branch target
- ir_write  out  1  IR load enable
- iord  out  1  memory address: 0 = PC, 1 = ALU result
- reg_write, alu_src, mem_read, mem_write, mem_to_reg  out  1 each  datapath controls
- alu_op  out  ALU_OP_W  000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT
- retire  out  1  one-cycle pulse when an instruction completes
- instret  out  CNT_W  retired-instruction count
- fault  out  1  sticky; high in the FAULT state
- state  out  3  current FSM state, for debug

## Operation
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, FAULT=5. Codes 6 and 7 go to FAULT.
- FETCH
  - Outputs: mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1, pc_src=0, next state DECODE. Otherwise stay in FETCH.
- DECODE
  - All controls are 0.
  - Legal instruction: next state EXEC. Illegal instruction: next state FAULT.
- Legal instruction set:
  - R-type 0110011, by funct3 (and funct7_5 where it matters): 000/0 ADD, 000/1 SUB, 111 AND, 110 OR, 010 SLT.
  - I-type 0010011: funct3 000, 111, 110 or 010; funct7_5 is ignored.
  - LW 0000011 and SW 0100011: funct3 must be 010.
  - Branch 1100011: funct3 000 (BEQ) or 001 (BNE).
  - Anything else is illegal.
- EXEC
  - R-type: alu_src=0, alu_op from funct; next state WB.
  - I-type: alu_src=1, same funct3 mapping with ADD for 000; next state WB.
  - LW/SW: alu_src=1, alu_op=ADD; next state MEM.
  - Branch: alu_src=0, alu_op=SUB, retire=1, next state FETCH.
  - Branch taken (BEQ with zero=1, or BNE with zero=0): pc_write=1 and pc_src=1.
- MEM
  - Outputs: iord=1, alu_src=1, alu_op=ADD held; mem_read=1 for LW, mem_write=1 for SW.
  - On mem_ready: LW goes to WB; SW asserts retire and goes to FETCH. Otherwise stay in MEM.
- WB
  - Outputs: reg_write=1, mem_to_reg=1 for LW (0 otherwise), retire=1; next state FETCH.
- FAULT
  - fault=1; all other controls 0; the block stays here until rst.
- Timeout (applies in FETCH and MEM)
  - A wait counter clears on entry to the state.
  - It increments on each cycle with mem_ready=0.
  - When the count reaches MEM_TIMEOUT, next state is FAULT.
  - mem_ready=1 in the same cycle wins over the timeout.
- instret increments on the edge after any retire and wraps modulo 2^CNT_W.
- Control outputs are combinational from state, the IR fields, zero and mem_ready; there are no other registered outputs.

## Timing
- Reset
  - While rst=1, all control outputs are forced to 0.
  - On the reset edge: state=FETCH, instret=0, fault=0, wait counter=0.
  - In the first cycle after release, mem_read=1.
  - rst mid-instruction aborts the instruction with no retire.
- Latency with mem_ready=1 on first request:
  - Branch: 3 cycles.
  - R-type, I-type, SW: 4 cycles.
  - LW: 5 cycles.
- Each wait cycle adds one cycle to that latency.
- mem_read and mem_write are held constant while waiting.
- retire is high for exactly one cycle per instruction, and never in the FAULT state.

## Test plan
- Reset, then ADD (0110011/000/0) with mem_ready=1 -> states 0,1,2,4; alu_op=000 in EXEC; reg_write=1 in WB; instret 0→1.
- LW (0000011/010) with mem_ready low 3 cycles in MEM -> MEM lasts 4 cycles with mem_read=1, iord=1; WB shows mem_to_reg=1; total 8 cycles.
- BEQ with zero=1, then BNE with zero=1 -> BEQ: pc_write=1, pc_src=1 in EXEC. BNE: pc_write=0. Both retire, instret +2.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH -> FAULT after 15 wait cycles; fault=1 sticky; no retire; rst returns to FETCH.
- Illegal R-type funct3=001, and opcode 1111111 -> DECODE→FAULT; reg_write and mem_write never asserted.
- SUB and SLTI, plus CNT_W=4 with 16 retires -> SUB alu_op=001 with alu_src=0; SLTI alu_op=100 with alu_src=1; instret wraps 15→0.
